// File: rtl/quadrature_generator_pkg.sv
// Shared types and Gray tables for the quadrature generator.
// Phase index 0..3 maps to {a,b}; every sequence starts and ends at 00.
package quadrature_generator_pkg;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  // Element [i] is {a,b} at phase index i.
  localparam logic [3:0][1:0] CW_TAB  = {2'b01, 2'b11, 2'b10, 2'b00};
  localparam logic [3:0][1:0] CCW_TAB = {2'b10, 2'b11, 2'b01, 2'b00};

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

endpackage

// File: rtl/quadrature_generator_if.sv
// Command handshake bundle for the quadrature generator.
// master offers a command, slave (the generator) accepts it.
interface quadrature_generator_if #(
  parameter int STEP_WIDTH  = 8,
  parameter int DWELL_WIDTH = 16
) ();

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_dir;
  logic [STEP_WIDTH-1:0]  cmd_steps;
  logic [DWELL_WIDTH-1:0] cmd_dwell;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_dwell,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_dwell,
    output cmd_ready
  );

endinterface

// File: rtl/quadrature_generator_phase_rom.sv
// Phase index + direction to {a,b} lookup.
// Purely combinational; sequencing lives in the top.
module quad_phase_rom
  import quadrature_generator_pkg::*;
(
  input  logic [1:0] idx,
  input  logic       dir,
  output logic [1:0] ab
);

  always_comb begin
    ab = 2'b00;
    unique case (1'b1)
      (dir == DIR_CW):  ab = CW_TAB[idx];
      (dir == DIR_CCW): ab = CCW_TAB[idx];
    endcase
  end

endmodule

// File: rtl/quadrature_generator.sv
// Rotary-encoder emulator: plays full Gray cycles at a set dwell
// and keeps a signed position count of completed cycles.
module quadrature_generator
  import quadrature_generator_pkg::*;
#(
  parameter int STEP_WIDTH  = 8,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  quadrature_generator_if.slave cmd,
  input  logic                  abort,
  output logic                  a,
  output logic                  b,
  output logic                  busy,
  output logic                  done,
  output logic [STEP_WIDTH-1:0] steps_left,
  output logic [STEP_WIDTH-1:0] position
);

  state_t                 state;
  logic                   dir_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic [DWELL_WIDTH-1:0] cnt;
  logic [1:0]             idx;
  logic [1:0]             idx_nxt;
  logic [1:0]             ab_nxt;
  logic                   ready_q;

  assign cmd.cmd_ready = ready_q;
  assign idx_nxt       = idx + 2'd1;

  quad_phase_rom u_rom (
    .idx (idx_nxt),
    .dir (dir_q),
    .ab  (ab_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      dir_q      <= DIR_CCW;
      dwell_q    <= '0;
      cnt        <= '0;
      idx        <= 2'd0;
      ready_q    <= 1'b1;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      steps_left <= '0;
      position   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd.cmd_valid) begin
            dir_q   <= cmd.cmd_dir;
            dwell_q <= cmd.cmd_dwell;
            if (cmd.cmd_steps == '0) begin
              done <= 1'b1;
            end else begin
              state      <= ST_RUN;
              busy       <= 1'b1;
              ready_q    <= 1'b0;
              steps_left <= cmd.cmd_steps;
              idx        <= 2'd0;
              cnt        <= '0;
            end
          end
        end
        ST_RUN: begin
          if (cnt == dwell_q) begin
            cnt    <= '0;
            idx    <= idx_nxt;
            {a, b} <= ab_nxt;
            // Back at 00: one full cycle done, abort only honoured here.
            if (idx_nxt == 2'd0) begin
              position <= (dir_q == DIR_CW)
                        ? position + STEP_WIDTH'(1)
                        : position - STEP_WIDTH'(1);
              if (steps_left == STEP_WIDTH'(1) || abort) begin
                state      <= ST_IDLE;
                busy       <= 1'b0;
                ready_q    <= 1'b1;
                done       <= 1'b1;
                steps_left <= '0;
              end else begin
                steps_left <= steps_left - STEP_WIDTH'(1);
              end
            end
          end else begin
            cnt <= cnt + DWELL_WIDTH'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quadrature_generator.sv
// Directed vector bench for quadrature_generator with a
// bench-side x4 quadrature decoder as the receive path.
module tb_quadrature_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       abort = 1'b0;
  logic       a, b, busy, done;
  logic [7:0] steps_left, position;

  quadrature_generator_if #(.STEP_WIDTH(8), .DWELL_WIDTH(16)) qif ();

  quadrature_generator #(.STEP_WIDTH(8), .DWELL_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (qif),
    .abort      (abort),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left),
    .position   (position)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dir;
    logic [7:0]  steps;
    logic [15:0] dwell;
    int          abort_cyc;
    logic [7:0]  exp_pos;
    int          exp_enc;
  } vec_t;

  logic [1:0] cw_seq  [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0] ccw_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  int n_chk  = 0;
  int n_fail = 0;
  int enc    = 0;
  logic [1:0] prev_ab = 2'b00;

  function automatic int cw_pos(input logic [1:0] ab);
    int p;
    p = 0;
    for (int i = 0; i < 4; i++)
      if (cw_seq[i] == ab) p = i;
    return p;
  endfunction

  always @(negedge clk) begin
    int d;
    d = (cw_pos({a, b}) - cw_pos(prev_ab)) & 3;
    if (d == 1) enc = enc + 1;
    else if (d == 3) enc = enc - 1;
    prev_ab = {a, b};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int per, n, exp_clk, e0, idx, cyc;
    logic [1:0] exp_ab;
    per     = int'(v.dwell) + 1;
    n       = (v.abort_cyc != 0) ? v.abort_cyc : int'(v.steps);
    exp_clk = 4 * n * per;
    cyc     = 4 * per;
    e0      = enc;
    qif.cmd_valid = 1'b1;
    qif.cmd_dir   = v.dir;
    qif.cmd_steps = v.steps;
    qif.cmd_dwell = v.dwell;
    step();
    qif.cmd_valid = 1'b0;
    if (v.steps == 8'd0) begin
      chk("zero_done", int'(done), 1);
      chk("zero_busy", int'(busy), 0);
      chk("zero_ready", int'(qif.cmd_ready), 1);
      chk("zero_ab", int'({a, b}), 0);
    end else begin
      chk("acc_busy", int'(busy), 1);
      chk("acc_ready", int'(qif.cmd_ready), 0);
      chk("acc_steps_left", int'(steps_left), int'(v.steps));
      for (int k = 1; k <= exp_clk; k++) begin
        if (v.abort_cyc != 0 && k == (v.abort_cyc - 1) * cyc + 1)
          abort = 1'b1;
        step();
        idx    = (k / per) % 4;
        exp_ab = v.dir ? cw_seq[idx] : ccw_seq[idx];
        chk("ab", int'({a, b}), int'(exp_ab));
        chk("done", int'(done), int'(k == exp_clk));
        if (k % cyc == 0)
          chk("steps_left", int'(steps_left),
              (k == exp_clk) ? 0 : int'(v.steps) - k / cyc);
      end
      abort = 1'b0;
      chk("end_busy", int'(busy), 0);
      chk("end_ready", int'(qif.cmd_ready), 1);
    end
    step();
    chk("post_done", int'(done), 0);
    chk("post_ab", int'({a, b}), 0);
    chk("position", int'(position), int'(v.exp_pos));
    chk("decoded", enc - e0, v.exp_enc);
  endtask

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 8'd2,  16'd3,  0, 8'h02,   8};
    vecs[1] = '{1'b0, 8'd3,  16'd0,  0, 8'hFF, -12};
    vecs[2] = '{1'b1, 8'd10, 16'd1,  2, 8'h01,   8};
    vecs[3] = '{1'b1, 8'd0,  16'd5,  0, 8'h01,   0};
    vecs[4] = '{1'b1, 8'd5,  16'd15, 0, 8'h06,  20};
    vecs[5] = '{1'b0, 8'd7,  16'd0,  0, 8'hFF, -28};

    qif.cmd_valid = 1'b0;
    qif.cmd_dir   = 1'b0;
    qif.cmd_steps = 8'd0;
    qif.cmd_dwell = 16'd0;
    repeat (3) step();
    reset = 1'b0;
    abort = 1'b1;
    repeat (10) step();
    abort = 1'b0;
    chk("rst_ab", int'({a, b}), 0);
    chk("rst_ready", int'(qif.cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pos", int'(position), 0);
    chk("rst_steps_left", int'(steps_left), 0);

    for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

    // Reset in the middle of a run.
    qif.cmd_valid = 1'b1;
    qif.cmd_dir   = 1'b1;
    qif.cmd_steps = 8'd3;
    qif.cmd_dwell = 16'd2;
    step();
    qif.cmd_valid = 1'b0;
    repeat (10) step();
    chk("mid_busy", int'(busy), 1);
    reset = 1'b1;
    step();
    chk("mr_ab", int'({a, b}), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_ready", int'(qif.cmd_ready), 1);
    chk("mr_steps_left", int'(steps_left), 0);
    chk("mr_pos", int'(position), 0);
    reset = 1'b0;
    step();
    v = '{1'b1, 8'd1, 16'd0, 0, 8'h01, 4};
    run_cmd(v);

    // cmd_valid held: accepts happen only on done cycles.
    qif.cmd_valid = 1'b1;
    qif.cmd_dir   = 1'b1;
    qif.cmd_steps = 8'd1;
    qif.cmd_dwell = 16'd0;
    step();
    for (int k = 1; k <= 19; k++) begin
      step();
      chk("hold_ready", int'(qif.cmd_ready), int'(k % 5 == 4));
      chk("hold_done", int'(done), int'(k % 5 == 4));
      chk("hold_busy", int'(busy), int'(k % 5 != 4));
    end
    qif.cmd_valid = 1'b0;
    step();
    chk("hold_idle", int'(busy), 0);
    chk("hold_pos", int'(position), 8'h05);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/quadrature_generator.md
Name: quadrature_generator

Overview:
- Synthesises two-phase quadrature signals (a, b), emulating a rotary encoder for self-test and bench stimulus of the debounce + encoder receive path.
- Accepts a command (direction, step count, phase dwell) over a valid/ready handshake and plays out full Gray-code cycles at a programmable rate.
- Tracks a signed position so benches can cross-check the decoded value.

Parameters:
- STEP_WIDTH, 8, width of cmd_steps, steps_left and position.
- DWELL_WIDTH, 16, width of cmd_dwell (cycles per phase minus one).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  generator idle, command accepted when cmd_valid & cmd_ready
- cmd_dir  in  1  1 = clockwise (a leads b), 0 = counter-clockwise (b leads a)
- cmd_steps  in  STEP_WIDTH  number of full quadrature cycles
- cmd_dwell  in  DWELL_WIDTH  each phase held cmd_dwell+1 clocks
- abort  in  1  finish current cycle, then stop
- a  out  1  quadrature phase A, registered
- b  out  1  quadrature phase B, registered
- busy  out  1  command in progress
- done  out  1  one-clock pulse at command completion
- steps_left  out  STEP_WIDTH  cycles remaining, including the one in progress
- position  out  STEP_WIDTH  two's-complement count: +1 per completed CW cycle, -1 per completed CCW cycle; wraps

Behaviour:
- Reset values:
  - a=0, b=0, busy=0, done=0, cmd_ready=1, steps_left=0, position=0.
  - All internal counters cleared, state IDLE.
  - Reset mid-command drops the command immediately; outputs return to reset values on the next edge.
- Gray sequences, starting and ending at (a,b)=00:
  - CW: 00→10→11→01→00.
  - CCW: 00→01→11→10→00.
  - One step = 4 transitions.
- States:
  - IDLE: cmd_ready=1. On accept at edge T:
    - latch dir, dwell, steps;
    - if steps=0, pulse done for the cycle after T; stay in IDLE; busy stays 0; no edges;
    - else go to RUN with busy=1, steps_left=cmd_steps, phase index 0, dwell counter 0.
  - RUN: dwell counter counts 0..dwell.
    - On the edge where counter==dwell: advance phase index (mod 4), update a/b, clear counter.
    - Exactly one of a/b changes per transition. Transition k (1-based) occurs at edge T+k*(dwell+1).
    - On transition to index 0 (cycle complete):
      - position ±1 per dir;
      - steps_left -1;
      - if steps_left was 1, or abort is high on that edge: go to IDLE, busy=0, cmd_ready=1, done=1 for one cycle (same edge as the final 00).
- Abort:
  - Sampled only at cycle-completion edges; never leaves a/b outside 00.
  - steps_left is cleared to 0 on an abort exit.
  - Abort in IDLE is ignored.
- Command inputs are ignored while busy. cmd_ready=0 from the edge after accept until done.
- Back-to-back: a command offered while done=1 is accepted that cycle.
- Total duration: 4*steps*(dwell+1) clocks from accept to done.
- dwell=0 gives one transition per clock.
- position wraps modulo 2^STEP_WIDTH.
- Dwell of at least 9 clocks is required for debounced receivers with 8-sample history. This is a usage rule; the generator does not enforce it.

Decomposition:
- Shared package holds:
  - CW/CCW Gray tables (2-bit phase → {a,b}) and direction encoding constants;
  - state enum (IDLE, RUN).
- Natural sub-module: quad_phase_rom, a combinational phase-index+dir → {a,b} lookup. All sequencing stays in quadrature_generator.

Test Plan:
- Reset, then idle for 10 clocks → a=b=0, cmd_ready=1, busy=0, position=0.
- Accept CW, steps=2, dwell=3 at edge T:
  - a/b sequence 10,11,01,00,10,11,01,00 at edges T+4, T+8 … T+32;
  - done pulses at T+32; position=2.
- Accept CCW, steps=3, dwell=0:
  - sequence 01,11,10,00 repeated each clock, 12 transitions;
  - position=-3 (8'hFD); steps_left decrements at each 00.
- Accept CW, steps=10, dwell=1; assert abort during the 2nd cycle:
  - stops at 00 after exactly 2 cycles (16 clocks);
  - done=1, steps_left=0, position +2.
- Accept steps=0 → done pulse next cycle, no a/b activity.
- Loop into the debounce+encoder path with dwell=15, CW, steps=5 → decoded value increments consistently.
- Assert reset mid-RUN → a=b=0, idle next edge; a new command then runs cleanly.
- Hold cmd_valid continuously → new commands are accepted only on done cycles.
